// File: rtl/sa_result_drain_pkg.sv
// Shared types and defaults for the systolic-array result drain.
// Partial-sum lane type, row bundle and sizing helpers.
package sa_result_drain_pkg;

  localparam int SA_N_DEFAULT     = 4;
  localparam int SA_DEPTH_DEFAULT = 8;
  localparam int SA_ACC_W         = 16;

  typedef logic signed [SA_ACC_W-1:0] int16_t;
  typedef int16_t psum_row_t [SA_N_DEFAULT];

  // Width of an occupancy counter that must reach depth itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sa_row_fifo.sv
// Generic synchronous row FIFO with occupancy count.
// Head data reads as zero while empty so the output is clean after reset.
module sa_row_fifo
  import sa_result_drain_pkg::*;
#(
  parameter int DEPTH = SA_DEPTH_DEFAULT,
  parameter int W     = SA_N_DEFAULT * SA_ACC_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // A full FIFO still takes a row when the head leaves the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rd_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      if (do_push & ~do_pop)
        cnt_q <= cnt_q + 1'b1;
      else if (do_pop & ~do_push)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Row storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= wdata;
  end

endmodule

// File: rtl/sa_result_drain.sv
// De-skews bottom-row partial sums into aligned rows and buffers them.
// Raises stall early enough that an obedient array never overflows.
module sa_result_drain
  import sa_result_drain_pkg::*;
#(
  parameter int N     = SA_N_DEFAULT,
  parameter int DEPTH = SA_DEPTH_DEFAULT,
  parameter int ACC_W = SA_ACC_W,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic [N*ACC_W-1:0] psum_i,
  input  logic [N-1:0]       psum_v_i,
  output logic [N*ACC_W-1:0] row_o,
  output logic               row_v_o,
  input  logic               row_ready_i,
  output logic               stall_o,
  output logic [CW-1:0]      count_o,
  output logic               overflow_o,
  output logic               skew_err_o
);

  // Sum of occupancy and in-flight rows stays below 2*DEPTH.
  localparam int SW = CW + 1;

  logic [N-1:0]       av;
  logic [N*ACC_W-1:0] ad;
  logic [N-2:0]       c0_v;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               skew;
  logic               drop;
  logic [SW-1:0]      inflight;
  logic               stall_d;
  logic               stall_q;
  logic               ovf_q;
  logic               skw_q;

  for (genvar j = 0; j < N - 1; j++) begin : g_col
    localparam int S = N - 1 - j;
    logic [S-1:0]     v_q;
    logic [ACC_W-1:0] d_q [S];

    // Valid delay line for column j.
    always_ff @(posedge clk_i) begin
      if (reset) begin
        v_q <= '0;
      end else begin
        v_q[0] <= psum_v_i[j];
        for (int k = 1; k < S; k++)
          v_q[k] <= v_q[k-1];
      end
    end

    // Data delay line for column j, free-running.
    always_ff @(posedge clk_i) begin
      d_q[0] <= psum_i[j*ACC_W +: ACC_W];
      for (int k = 1; k < S; k++)
        d_q[k] <= d_q[k-1];
    end

    assign av[j]              = v_q[S-1];
    assign ad[j*ACC_W +: ACC_W] = d_q[S-1];

    if (j == 0) begin : g_c0
      assign c0_v = v_q;
    end
  end

  assign av[N-1]                  = psum_v_i[N-1];
  assign ad[(N-1)*ACC_W +: ACC_W] = psum_i[(N-1)*ACC_W +: ACC_W];

  assign push    = &av;
  assign skew    = (|av) & ~(&av);
  assign row_v_o = ~empty;
  assign pop     = row_v_o & row_ready_i;
  assign drop    = push & full & ~pop;

  sa_row_fifo #(
    .DEPTH (DEPTH),
    .W     (N * ACC_W)
  ) u_fifo (
    .clk_i (clk_i),
    .reset (reset),
    .push  (push),
    .wdata (ad),
    .pop   (pop),
    .rdata (row_o),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  // Rows launched but not yet aligned, plus stall threshold.
  always_comb begin
    inflight = '0;
    for (int k = 0; k < N - 1; k++)
      inflight = inflight + SW'(c0_v[k]);
    stall_d = (SW'(count_o) + inflight) >= SW'(DEPTH - 1);
  end

  // Registered stall and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      stall_q <= 1'b0;
      ovf_q   <= 1'b0;
      skw_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      if (drop) ovf_q <= 1'b1;
      if (skew) skw_q <= 1'b1;
    end
  end

  assign stall_o    = stall_q;
  assign overflow_o = ovf_q;
  assign skew_err_o = skw_q;

endmodule
